// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe: byte-enabled 1W/1R RAM, write-first bypass, post-reset clear
// sweep, read latency 1 or 2. Define RAM_PARITY_EN for per-byte even parity.
module dual_port_ram_pipe #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      write,
    input  logic [ADDR_WIDTH-1:0]     wr_address,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [DATA_WIDTH/8-1:0]   wr_byte_en,
    input  logic                      read,
    input  logic [ADDR_WIDTH-1:0]     rd_address,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      busy,
    input  logic                      wr_parity_flip,
    output logic                      parity_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    hit;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic [BYTES-1:0]        mem_be;

    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    rd_err;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_valid;
    logic                    o_err;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    if (clr_addr == LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                end
            endcase
        end
    end

    assign wr_fire = write & (state == READY);
    assign rd_fire = read & (state == READY);
    assign hit     = wr_fire & (wr_address == rd_address);

    // The clear sweep and normal writes share the single write port
    always_comb begin
        mem_wa = wr_address;
        mem_wd = data_in;
        mem_be = wr_fire ? wr_byte_en : '0;
        if (state == CLEAR) begin
            mem_wa = clr_addr;
            mem_wd = '0;
            mem_be = '1;
        end
    end

    always_comb begin
        rd_word = mem[rd_address];
        for (int i = 0; i < BYTES; i++) begin
            if (hit && wr_byte_en[i])
                rd_word[8*i +: 8] = data_in[8*i +: 8];
        end
    end

`ifdef RAM_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];
    logic [BYTES-1:0] wr_par;
    logic [BYTES-1:0] mem_pd;
    logic [BYTES-1:0] rd_par;
    logic [BYTES-1:0] rd_calc;

    always_comb begin
        wr_par  = '0;
        rd_par  = par_mem[rd_address];
        rd_calc = '0;
        for (int i = 0; i < BYTES; i++) begin
            wr_par[i] = (^data_in[8*i +: 8]) ^ wr_parity_flip;
            if (hit && wr_byte_en[i])
                rd_par[i] = wr_par[i];
            rd_calc[i] = ^rd_word[8*i +: 8];
        end
    end

    assign mem_pd = (state == CLEAR) ? '0 : wr_par;
    assign rd_err = |(rd_calc ^ rd_par);
`else
    logic unused_flip;
    assign unused_flip = wr_parity_flip;
    assign rd_err      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        for (int i = 0; i < BYTES; i++) begin
            if (mem_be[i]) begin
                mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
`ifdef RAM_PARITY_EN
                par_mem[mem_wa][i] <= mem_pd[i];
`endif
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_data;
            logic                  s1_valid;
            logic                  s1_err;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    s1_data  <= '0;
                    s1_valid <= 1'b0;
                    s1_err   <= 1'b0;
                end else begin
                    s1_valid <= rd_fire;
                    s1_err   <= rd_fire & rd_err;
                    if (rd_fire)
                        s1_data <= rd_word;
                end
            end

            assign o_data  = s1_data;
            assign o_valid = s1_valid;
            assign o_err   = s1_err;
        end else begin : g_lat1
            assign o_data  = rd_word;
            assign o_valid = rd_fire;
            assign o_err   = rd_err;
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            data_valid <= o_valid;
            parity_err <= o_valid & o_err;
            if (o_valid)
                data_out <= o_data;
        end
    end

endmodule
